boot_run_ctrl: RTL and testbench
================================

Name: boot_run_ctrl

Overview:
Synthesizable boot/run sequencer for the testharness and FPGA top. Holds the core in reset for a fixed number of cycles after system reset and latches the boot straps. It then waits for the firmware load to finish and releases fetch. While the program runs it supervises termination: an exit report or a cycle-limit watchdog ends the run, and the block reports pass, fail or timeout.

Parameters:
RESET_WAIT_CYCLES, 50, cycles core reset is held after rst_ni deassertion (must be >= 1).
CNT_W, 32, width of the run-cycle counter and the max-cycles limit.

Ports:
clk_i  in  1  system clock.
rst_ni  in  1  reset, asynchronous, active-low.
boot_select_i  in  1  boot strap: 0 = jtag/preload, 1 = flash.
execute_from_flash_i  in  1  SPI strap: 1 = memory-mapped flash; only meaningful when boot_select_i=1.
load_done_i  in  1  firmware-loaded indication (level or single-cycle pulse).
max_cycles_i  in  CNT_W  watchdog limit; 0 disables the watchdog.
exit_valid_i  in  1  program exit report.
exit_value_i  in  32  program exit code.
core_rst_no  out  1  reset to the core/SoC, active-low.
fetch_enable_o  out  1  core fetch enable.
boot_select_o  out  1  latched boot strap.
execute_from_flash_o  out  1  latched SPI strap, gated by boot_select.
state_o  out  3  current FSM state code.
cycle_cnt_o  out  CNT_W  cycles spent in RUN.
done_o  out  1  run terminated (any reason).
pass_o  out  1  exited with code 0.
fail_o  out  1  exited with nonzero code.
timeout_o  out  1  watchdog expired.
exit_value_o  out  32  captured exit code.

Behaviour:
- The interface has one clock, clk_i. Reset rst_ni is asynchronous and active-low.
- Reset value of every output is 0. Reset forces state HOLD.
- All outputs are registered or decoded from registered state; there are no combinational input-to-output paths.
- State encoding: HOLD=0, STRAP=1, LOAD=2, RUN=3, PASS=4, FAIL=5, TIMEOUT=6.
- HOLD:
  - A wait counter starts at 0 and increments every cycle.
  - The state moves to STRAP on the edge where the counter equals RESET_WAIT_CYCLES-1.
  - core_rst_no=0 throughout.
- STRAP (exactly 1 cycle):
  - Latch boot_select_o <= boot_select_i.
  - Latch execute_from_flash_o <= execute_from_flash_i & boot_select_i.
  - Next state is LOAD if boot_select_i=0, else RUN.
  - The straps are ignored after this cycle until the next reset.
- core_rst_no=1 in every state from LOAD onward. If boot_select=1 it rises directly on entry to RUN.
  - Net effect: core_rst_no rises on posedge RESET_WAIT_CYCLES+1 after rst_ni release.
- LOAD:
  - fetch_enable_o=0.
  - load_done_i=1 on any cycle moves the state to RUN on the next edge.
  - There is no timeout in LOAD.
- RUN:
  - fetch_enable_o=1.
  - cycle_cnt_o clears to 0 on entry and increments by 1 each cycle in RUN. It saturates at all-ones and never wraps.
  - exit_valid_i=1 captures exit_value_i into exit_value_o. The next state is PASS if the value is 0, else FAIL.
  - Otherwise, if max_cycles_i!=0 and cycle_cnt_o==max_cycles_i, the next state is TIMEOUT.
  - Exit has priority over timeout when both occur in the same cycle.
- PASS/FAIL/TIMEOUT:
  - Terminal and sticky until rst_ni.
  - done_o=1; the matching flag among pass_o/fail_o/timeout_o is 1, exactly one-hot.
  - fetch_enable_o=0; core_rst_no stays 1; cycle_cnt_o and exit_value_o are frozen.
- exit_valid_i is ignored outside RUN (no capture, no state change). load_done_i is ignored outside LOAD.
- max_cycles_i is sampled live every RUN cycle. Lowering it below the current count does not trigger a timeout, because the comparison is equality. Software must set the limit before RUN.
- Reset mid-operation: all state, counters, latched straps and flags clear immediately and asynchronously. The sequence restarts from HOLD on rst_ni release.

Test Plan:
1. RESET_WAIT_CYCLES=4, boot_select_i=0, release rst_ni -> core_rst_no rises at 5th posedge, state_o=2, fetch_enable_o=0; pulse load_done_i for 1 cycle -> state_o=3, fetch_enable_o=1 next edge.
2. In RUN, assert exit_valid_i with exit_value_i=0 after 10 RUN cycles -> pass_o=1, done_o=1, cycle_cnt_o=10, fetch_enable_o=0; later exit_valid_i with value 5 -> exit_value_o remains 0.
3. exit_valid_i with exit_value_i=3 -> fail_o=1, pass_o=0, exit_value_o=3, state_o=5.
4. max_cycles_i=20, no exit -> timeout_o=1 when cycle_cnt_o reaches 20, state_o=6; repeat with exit_valid_i (value 0) on the cycle the count hits 20 -> pass_o=1, timeout_o=0.
5. Straps boot_select_i=1, execute_from_flash_i=1 -> LOAD skipped (state 1->3), execute_from_flash_o=1; straps 0/1 -> execute_from_flash_o=0; toggling straps after STRAP -> latched outputs unchanged.
6. Assert rst_ni low mid-RUN between clock edges -> all outputs 0 immediately; release -> full sequence repeats, with core_rst_no rising again after RESET_WAIT_CYCLES+1 edges.

Source files
------------

// File: rtl/boot_run_ctrl.sv
// Boot/run sequencer: holds the core in reset, latches boot straps, waits for the firmware load,
// then supervises the run and ends it on an exit report or a watchdog timeout.
module boot_run_ctrl #(
    parameter int RESET_WAIT_CYCLES = 50,
    parameter int CNT_W             = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             boot_select_i,
    input  logic             execute_from_flash_i,
    input  logic             load_done_i,
    input  logic [CNT_W-1:0] max_cycles_i,
    input  logic             exit_valid_i,
    input  logic [31:0]      exit_value_i,
    output logic             core_rst_no,
    output logic             fetch_enable_o,
    output logic             boot_select_o,
    output logic             execute_from_flash_o,
    output logic [2:0]       state_o,
    output logic [CNT_W-1:0] cycle_cnt_o,
    output logic             done_o,
    output logic             pass_o,
    output logic             fail_o,
    output logic             timeout_o,
    output logic [31:0]      exit_value_o
);

    typedef enum logic [2:0] {
        HOLD    = 3'd0,
        STRAP   = 3'd1,
        LOAD    = 3'd2,
        RUN     = 3'd3,
        PASS    = 3'd4,
        FAIL    = 3'd5,
        TIMEOUT = 3'd6
    } state_t;

    localparam int WAIT_W = (RESET_WAIT_CYCLES > 1) ? $clog2(RESET_WAIT_CYCLES) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(RESET_WAIT_CYCLES - 1);

    state_t            state_q;
    state_t            state_d;
    logic [WAIT_W-1:0] wait_cnt_q;
    logic [CNT_W-1:0]  cycle_cnt_q;
    logic [31:0]       exit_value_q;
    logic              boot_select_q;
    logic              exec_flash_q;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            HOLD:    if (wait_cnt_q == WAIT_LAST) state_d = STRAP;
            STRAP:   state_d = boot_select_i ? RUN : LOAD;
            LOAD:    if (load_done_i) state_d = RUN;
            RUN: begin
                // An exit report wins over a watchdog hit in the same cycle
                if (exit_valid_i) begin
                    state_d = (exit_value_i == 32'd0) ? PASS : FAIL;
                end else if ((max_cycles_i != '0) && (cycle_cnt_q == max_cycles_i)) begin
                    state_d = TIMEOUT;
                end
            end
            PASS, FAIL, TIMEOUT: state_d = state_q;
            default: state_d = HOLD;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= HOLD;
        else         state_q <= state_d;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wait_cnt_q    <= '0;
            cycle_cnt_q   <= '0;
            exit_value_q  <= '0;
            boot_select_q <= 1'b0;
            exec_flash_q  <= 1'b0;
        end else begin
            if ((state_q == HOLD) && (wait_cnt_q != WAIT_LAST)) begin
                wait_cnt_q <= wait_cnt_q + 1'b1;
            end
            if (state_q == STRAP) begin
                boot_select_q <= boot_select_i;
                exec_flash_q  <= execute_from_flash_i & boot_select_i;
            end
            // The count freezes on the edge that leaves RUN, so it reflects the terminating cycle
            if ((state_q != RUN) && (state_d == RUN)) begin
                cycle_cnt_q <= '0;
            end else if ((state_q == RUN) && (state_d == RUN) && (cycle_cnt_q != {CNT_W{1'b1}})) begin
                cycle_cnt_q <= cycle_cnt_q + 1'b1;
            end
            if ((state_q == RUN) && exit_valid_i) begin
                exit_value_q <= exit_value_i;
            end
        end
    end

    assign core_rst_no          = (state_q != HOLD) && (state_q != STRAP);
    assign fetch_enable_o       = (state_q == RUN);
    assign boot_select_o        = boot_select_q;
    assign execute_from_flash_o = exec_flash_q;
    assign state_o              = state_q;
    assign cycle_cnt_o          = cycle_cnt_q;
    assign done_o               = (state_q == PASS) || (state_q == FAIL) || (state_q == TIMEOUT);
    assign pass_o               = (state_q == PASS);
    assign fail_o               = (state_q == FAIL);
    assign timeout_o            = (state_q == TIMEOUT);
    assign exit_value_o         = exit_value_q;

endmodule

// File: tb/tb_boot_run_ctrl.sv
// Scoreboard bench for boot_run_ctrl: expected outputs are queued as stimulus is applied
// and checked against the DUT after the clock edge that should produce them.
module tb_boot_run_ctrl;

    localparam int RWC   = 4;
    localparam int CNT_W = 8;

    localparam logic [63:0] S_HOLD = 64'd0, S_STRAP = 64'd1, S_LOAD = 64'd2, S_RUN = 64'd3;
    localparam logic [63:0] S_PASS = 64'd4, S_FAIL = 64'd5, S_TIMEOUT = 64'd6;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             boot_select = 1'b0;
    logic             exec_flash = 1'b0;
    logic             load_done = 1'b0;
    logic [CNT_W-1:0] max_cycles = '0;
    logic             exit_valid = 1'b0;
    logic [31:0]      exit_value = '0;

    logic             core_rst_n;
    logic             fetch_enable;
    logic             boot_select_lat;
    logic             exec_flash_lat;
    logic [2:0]       state;
    logic [CNT_W-1:0] cycle_cnt;
    logic             done;
    logic             pass;
    logic             fail;
    logic             timeout;
    logic [31:0]      exit_value_lat;

    int n_compared = 0;
    int n_mismatched = 0;

    typedef struct {
        string       tag;
        logic [63:0] value;
    } exp_t;

    exp_t exp_q[$];

    boot_run_ctrl #(.RESET_WAIT_CYCLES(RWC), .CNT_W(CNT_W)) dut (
        .clk_i(clk),
        .rst_ni(rst_n),
        .boot_select_i(boot_select),
        .execute_from_flash_i(exec_flash),
        .load_done_i(load_done),
        .max_cycles_i(max_cycles),
        .exit_valid_i(exit_valid),
        .exit_value_i(exit_value),
        .core_rst_no(core_rst_n),
        .fetch_enable_o(fetch_enable),
        .boot_select_o(boot_select_lat),
        .execute_from_flash_o(exec_flash_lat),
        .state_o(state),
        .cycle_cnt_o(cycle_cnt),
        .done_o(done),
        .pass_o(pass),
        .fail_o(fail),
        .timeout_o(timeout),
        .exit_value_o(exit_value_lat)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        n_compared++;
        if (observed !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, observed, expected, $time);
        end
    endtask

    function automatic logic [63:0] observe(input string tag);
        if (tag == "state")      return 64'(state);
        if (tag == "core_rst")   return 64'(core_rst_n);
        if (tag == "fetch")      return 64'(fetch_enable);
        if (tag == "done")       return 64'(done);
        if (tag == "pass")       return 64'(pass);
        if (tag == "fail")       return 64'(fail);
        if (tag == "timeout")    return 64'(timeout);
        if (tag == "cnt")        return 64'(cycle_cnt);
        if (tag == "exit_value") return 64'(exit_value_lat);
        if (tag == "boot_sel")   return 64'(boot_select_lat);
        if (tag == "exec_flash") return 64'(exec_flash_lat);
        return 64'hDEAD_BEEF_DEAD_BEEF;
    endfunction

    task automatic expect_val(input string tag, input logic [63:0] value);
        exp_t e;
        e.tag   = tag;
        e.value = value;
        exp_q.push_back(e);
    endtask

    // Status outputs implied by a given FSM state
    task automatic expect_state(input logic [63:0] s);
        expect_val("state", s);
        expect_val("core_rst", 64'(s >= S_LOAD));
        expect_val("fetch", 64'(s == S_RUN));
        expect_val("done", 64'(s >= S_PASS));
        expect_val("pass", 64'(s == S_PASS));
        expect_val("fail", 64'(s == S_FAIL));
        expect_val("timeout", 64'(s == S_TIMEOUT));
    endtask

    task automatic expect_all_zero();
        expect_state(S_HOLD);
        expect_val("cnt", 64'd0);
        expect_val("exit_value", 64'd0);
        expect_val("boot_sel", 64'd0);
        expect_val("exec_flash", 64'd0);
    endtask

    task automatic check_pending();
        exp_t e;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check_output(e.tag, observe(e.tag), e.value);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_exit(input logic [31:0] value);
        exit_valid = 1'b1;
        exit_value = value;
        tick();
        exit_valid = 1'b0;
    endtask

    // Reset with a mid-cycle release, then walk HOLD -> STRAP -> (LOAD) -> RUN
    task automatic apply_stimulus(input logic bs, input logic ef, input logic [CNT_W-1:0] max_c);
        boot_select = bs;
        exec_flash  = ef;
        max_cycles  = max_c;
        tick();
        #2 rst_n = 1'b0;
        #1;
        expect_all_zero();
        check_pending();
        #3 rst_n = 1'b1;
        tick(RWC - 1);
        expect_state(S_HOLD);
        check_pending();
        tick();
        expect_state(S_STRAP);
        check_pending();
        tick();
        expect_val("boot_sel", 64'(bs));
        expect_val("exec_flash", 64'(bs & ef));
        if (bs) begin
            expect_state(S_RUN);
            expect_val("cnt", 64'd0);
            check_pending();
        end else begin
            expect_state(S_LOAD);
            check_pending();
            pulse_exit(32'd7);
            expect_state(S_LOAD);
            expect_val("exit_value", 64'd0);
            check_pending();
            load_done = 1'b1;
            tick();
            load_done = 1'b0;
            expect_state(S_RUN);
            expect_val("cnt", 64'd0);
            check_pending();
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, compared %0d", n_compared);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        #3;
        expect_all_zero();
        check_pending();

        // Jtag boot, exit code 0 after 10 RUN cycles, later exit ignored
        apply_stimulus(1'b0, 1'b0, '0);
        tick(10);
        expect_state(S_RUN);
        expect_val("cnt", 64'd10);
        check_pending();
        pulse_exit(32'd0);
        expect_state(S_PASS);
        expect_val("cnt", 64'd10);
        expect_val("exit_value", 64'd0);
        check_pending();
        pulse_exit(32'd5);
        tick(2);
        expect_state(S_PASS);
        expect_val("exit_value", 64'd0);
        expect_val("cnt", 64'd10);
        check_pending();

        // Nonzero exit code
        apply_stimulus(1'b0, 1'b0, '0);
        tick(4);
        pulse_exit(32'd3);
        expect_state(S_FAIL);
        expect_val("exit_value", 64'd3);
        expect_val("cnt", 64'd4);
        check_pending();

        // Watchdog expiry at 20 cycles, then frozen
        apply_stimulus(1'b0, 1'b0, 8'd20);
        tick(20);
        expect_state(S_RUN);
        expect_val("cnt", 64'd20);
        check_pending();
        tick();
        expect_state(S_TIMEOUT);
        expect_val("cnt", 64'd20);
        check_pending();
        pulse_exit(32'd0);
        tick(2);
        expect_state(S_TIMEOUT);
        expect_val("cnt", 64'd20);
        expect_val("exit_value", 64'd0);
        check_pending();

        // Exit and watchdog in the same cycle: exit wins
        apply_stimulus(1'b0, 1'b0, 8'd20);
        tick(20);
        pulse_exit(32'd0);
        expect_state(S_PASS);
        expect_val("cnt", 64'd20);
        check_pending();

        // Flash boot skips LOAD; straps ignored after STRAP
        apply_stimulus(1'b1, 1'b1, '0);
        boot_select = 1'b0;
        exec_flash  = 1'b0;
        tick(3);
        expect_state(S_RUN);
        expect_val("boot_sel", 64'd1);
        expect_val("exec_flash", 64'd1);
        expect_val("cnt", 64'd3);
        check_pending();
        apply_stimulus(1'b0, 1'b1, '0);
        apply_stimulus(1'b1, 1'b0, '0);

        // Asynchronous reset mid-RUN, then the sequence repeats
        apply_stimulus(1'b1, 1'b1, '0);
        tick(5);
        #2 rst_n = 1'b0;
        #1;
        expect_all_zero();
        check_pending();
        #3 rst_n = 1'b1;
        tick(RWC);
        expect_state(S_STRAP);
        check_pending();
        tick();
        expect_state(S_RUN);
        expect_val("exec_flash", 64'd1);
        check_pending();

        // Run counter saturates instead of wrapping
        apply_stimulus(1'b0, 1'b0, '0);
        tick(300);
        expect_state(S_RUN);
        expect_val("cnt", 64'd255);
        check_pending();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
